// File: rtl/alu_ctl_pkg.sv
// Shared ALU control definitions: opcode constants and multiply-sequencer states.
package alu_ctl_pkg;

  localparam logic [3:0] ALU_OP_ROL = 4'b0000;
  localparam logic [3:0] ALU_OP_ROR = 4'b0001;
  localparam logic [3:0] ALU_OP_SLL = 4'b0010;
  localparam logic [3:0] ALU_OP_SRA = 4'b0011;
  localparam logic [3:0] ALU_OP_SRL = 4'b0100;
  localparam logic [3:0] ALU_OP_ADD = 4'b1000;
  localparam logic [3:0] ALU_OP_XOR = 4'b1010;
  localparam logic [3:0] ALU_OP_AND = 4'b1011;
  localparam logic [3:0] ALU_OP_SCO = 4'b1100;
  localparam logic [3:0] ALU_OP_SLE = 4'b1101;
  localparam logic [3:0] ALU_OP_SLT = 4'b1110;
  localparam logic [3:0] ALU_OP_SEQ = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add multiplier that borrows the shared ALU: ADD accumulates a
// partial product, SLL doubles the multiplicand. Produces the low WIDTH bits of
// a*b and an exact flag for a full product that does not fit in WIDTH bits.
module alu_mul_seq
  import alu_ctl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_cin,
  output logic             alu_passthrough,
  output logic             alu_reverse,
  output logic             alu_inva,
  output logic             alu_invb,
  output logic             alu_sign,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_ofl
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             ovf_r_q, ovf_r_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;

  // State and datapath registers; reset clears everything including the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= ZERO_W;
      mcand_q  <= ZERO_W;
      mplier_q <= ZERO_W;
      ovf_r_q  <= 1'b0;
      result_q <= ZERO_W;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      ovf_r_q  <= ovf_r_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state and datapath update; result/ovf are latched on the edge into DONE.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    ovf_r_d  = ovf_r_q;
    result_d = result_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = ZERO_W;
          ovf_r_d  = 1'b0;
          if (b == ZERO_W) begin
            state_d = ST_DONE;
          end else if (b[0]) begin
            state_d = ST_ADD;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        acc_d   = alu_out;
        ovf_r_d = ovf_r_q | alu_ofl;
        // No higher multiplier bits left: the trailing shift would be wasted.
        if (mplier_q[WIDTH-1:1] == ZERO_W[WIDTH-1:1]) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        mcand_d  = alu_out;
        mplier_d = mplier_q >> 1;
        // A multiplicand bit falling off the top only matters if some later
        // multiplier bit would still add it in.
        ovf_r_d  = ovf_r_q | (mcand_q[WIDTH-1] &
                   (mplier_q[WIDTH-1:1] != ZERO_W[WIDTH-1:1]));
        if (mplier_d == ZERO_W) begin
          state_d = ST_DONE;
        end else if (mplier_d[0]) begin
          state_d = ST_ADD;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over every transition and leaves the datapath untouched.
    if (flush) begin
      state_d  = ST_IDLE;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      ovf_r_d  = ovf_r_q;
    end else begin
      state_d = state_d;
    end

    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      result_d = acc_d;
      ovf_d    = ovf_r_d;
    end else begin
      result_d = result_q;
      ovf_d    = ovf_q;
    end
  end

  // ALU operand steering and status flags, decoded from the current state only.
  always_comb begin
    alu_own = 1'b0;
    alu_a   = ZERO_W;
    alu_b   = ZERO_W;
    alu_op  = 4'b0000;
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    case (state_q)
      ST_ADD: begin
        alu_own = 1'b1;
        alu_a   = acc_q;
        alu_b   = mcand_q;
        alu_op  = ALU_OP_ADD;
      end
      ST_SHIFT: begin
        alu_own = 1'b1;
        alu_a   = mcand_q;
        alu_b   = ONE_W;
        alu_op  = ALU_OP_SLL;
      end
      default: begin
        alu_own = 1'b0;
      end
    endcase
  end

  assign result          = result_q;
  assign ovf             = ovf_q;
  assign alu_cin         = 1'b0;
  assign alu_passthrough = 1'b0;
  assign alu_reverse     = 1'b0;
  assign alu_inva        = 1'b0;
  assign alu_invb        = 1'b0;
  assign alu_sign        = 1'b0;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed testbench for alu_mul_seq with a behavioural model of the shared ALU.
module tb_alu_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovf;
  logic        alu_own;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic        alu_cin, alu_passthrough, alu_reverse, alu_inva, alu_invb, alu_sign;
  logic [15:0] alu_out;
  logic        alu_ofl;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic        own_tr  [0:63];
  logic        busy_tr [0:63];
  logic [3:0]  op_tr   [0:63];
  logic [15:0] a_tr    [0:63];
  logic [15:0] b_tr    [0:63];
  logic        tie_any;
  int          done_cyc;
  int          done_cnt;

  alu_mul_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .ovf(ovf), .alu_own(alu_own),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_passthrough(alu_passthrough), .alu_reverse(alu_reverse),
    .alu_inva(alu_inva), .alu_invb(alu_invb), .alu_sign(alu_sign),
    .alu_out(alu_out), .alu_ofl(alu_ofl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: only the ops the sequencer uses; Ofl is the unsigned carry for ADD.
  always_comb begin
    alu_out = 16'h0000;
    alu_ofl = 1'b0;
    case (alu_op)
      4'b1000: {alu_ofl, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0010: alu_out = alu_a << alu_b[3:0];
      default: alu_out = 16'h0000;
    endcase
  end

  // Accept one multiply, then record per-cycle activity until done+2 or budget.
  task automatic do_mul(input logic [15:0] ta, input logic [15:0] tb_v,
                        input int budget, input bit busy_start, input int flush_at);
    for (int i = 0; i < 64; i++) begin
      own_tr[i] = 1'b0; busy_tr[i] = 1'b0; op_tr[i] = 4'h0;
      a_tr[i] = 16'h0; b_tr[i] = 16'h0;
    end
    tie_any  = 1'b0;
    done_cyc = -1;
    done_cnt = 0;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= budget; cyc++) begin
      #1;
      own_tr[cyc]  = alu_own;
      busy_tr[cyc] = busy;
      op_tr[cyc]   = alu_op;
      a_tr[cyc]    = alu_a;
      b_tr[cyc]    = alu_b;
      tie_any = tie_any | alu_cin | alu_passthrough | alu_reverse | alu_inva | alu_invb | alu_sign;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(negedge clk);
      start = 1'b0;
      if (busy_start && cyc == 2) begin
        start = 1'b1; a = 16'd7; b = 16'd7;
      end
      flush = (cyc == flush_at);
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tot_cnt++;
    if ({busy, done, result, ovf, alu_own, alu_a, alu_b, alu_op} !== 55'd0)
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h ovf=%b own=%b alu_a=%h alu_b=%h op=%h, need all 0",
               busy, done, result, ovf, alu_own, alu_a, alu_b, alu_op);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] own_bits;
    do_mul(16'd3, 16'd5, 40, 1'b0, 0);
    own_bits = 16'h0;
    for (int i = 0; i < 16; i++) own_bits[i] = own_tr[i];
    tot_cnt++;
    if (done_cyc !== 5) $display("FAIL basic_latency: done at %0d, need 5", done_cyc);
    else pass_cnt++;
    tot_cnt++;
    if (result !== 16'h000F || ovf !== 1'b0)
      $display("FAIL basic_result: got %h ovf=%b, need 000F ovf=0", result, ovf);
    else pass_cnt++;
    tot_cnt++;
    if (own_bits !== 16'h001E) $display("FAIL basic_own: own mask %h, need 001E", own_bits);
    else pass_cnt++;
    tot_cnt++;
    if ({op_tr[1], op_tr[2], op_tr[3], op_tr[4], op_tr[5]} !== 20'h82280)
      $display("FAIL basic_ops: got %h %h %h %h %h, need 8 2 2 8 0",
               op_tr[1], op_tr[2], op_tr[3], op_tr[4], op_tr[5]);
    else pass_cnt++;
    tot_cnt++;
    if (a_tr[1] !== 16'd0 || b_tr[1] !== 16'd3 || a_tr[3] !== 16'd6 || b_tr[3] !== 16'd1 ||
        a_tr[4] !== 16'd3 || b_tr[4] !== 16'd12 || a_tr[5] !== 16'd0 || b_tr[5] !== 16'd0)
      $display("FAIL basic_operands: c1 %h/%h c3 %h/%h c4 %h/%h c5 %h/%h, need 0/3 6/1 3/c 0/0",
               a_tr[1], b_tr[1], a_tr[3], b_tr[3], a_tr[4], b_tr[4], a_tr[5], b_tr[5]);
    else pass_cnt++;
    tot_cnt++;
    if (tie_any !== 1'b0) $display("FAIL basic_tieoffs: some tie-off was %b, need 0", tie_any);
    else pass_cnt++;
    tot_cnt++;
    if (busy_tr[6] !== 1'b0 || busy_tr[5] !== 1'b1 || done_cnt !== 1)
      $display("FAIL basic_busy: busy5=%b busy6=%b dones=%0d, need 1 0 1", busy_tr[5], busy_tr[6], done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_zero();
    do_mul(16'h1234, 16'd0, 40, 1'b0, 0);
    tot_cnt++;
    if (done_cyc !== 1 || result !== 16'h0000 || ovf !== 1'b0 || own_tr[1] !== 1'b0)
      $display("FAIL zero_mult: done@%0d result=%h ovf=%b own=%b, need done@1 0000 0 0",
               done_cyc, result, ovf, own_tr[1]);
    else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    do_mul(16'd3, 16'd5, 40, 1'b1, 0);
    tot_cnt++;
    if (done_cnt !== 1 || done_cyc !== 5 || result !== 16'h000F)
      $display("FAIL busy_start: dones=%0d done@%0d result=%h, need 1 @5 000F", done_cnt, done_cyc, result);
    else pass_cnt++;
  endtask

  task automatic test_carry();
    do_mul(16'h6000, 16'd3, 40, 1'b0, 0);
    tot_cnt++;
    if (done_cyc !== 4 || result !== 16'h2000 || ovf !== 1'b1)
      $display("FAIL carry_ovf: done@%0d result=%h ovf=%b, need @4 2000 1", done_cyc, result, ovf);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    do_mul(16'd3, 16'd5, 10, 1'b0, 3);
    tot_cnt++;
    if (done_cnt !== 0 || busy_tr[3] !== 1'b1 || busy_tr[4] !== 1'b0)
      $display("FAIL flush_abort: dones=%0d busy3=%b busy4=%b, need 0 1 0", done_cnt, busy_tr[3], busy_tr[4]);
    else pass_cnt++;
    tot_cnt++;
    if (result !== 16'h2000 || ovf !== 1'b1)
      $display("FAIL flush_retain: result=%h ovf=%b, need 2000 1", result, ovf);
    else pass_cnt++;
  endtask

  task automatic test_lost_bit();
    do_mul(16'h0100, 16'h0100, 40, 1'b0, 0);
    tot_cnt++;
    if (done_cyc !== 10 || result !== 16'h0000 || ovf !== 1'b1)
      $display("FAIL lost_bit: done@%0d result=%h ovf=%b, need @10 0000 1", done_cyc, result, ovf);
    else pass_cnt++;
    do_mul(16'h8000, 16'd1, 40, 1'b0, 0);
    tot_cnt++;
    if (done_cyc !== 2 || result !== 16'h8000 || ovf !== 1'b0)
      $display("FAIL top_bit_no_ovf: done@%0d result=%h ovf=%b, need @2 8000 0", done_cyc, result, ovf);
    else pass_cnt++;
  endtask

  task automatic test_max();
    do_mul(16'hFFFF, 16'hFFFF, 40, 1'b0, 0);
    tot_cnt++;
    if (done_cyc !== 32 || result !== 16'h0001 || ovf !== 1'b1)
      $display("FAIL max_operands: done@%0d result=%h ovf=%b, need @32 0001 1", done_cyc, result, ovf);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    tot_cnt++;
    if (busy !== 1'b1) $display("FAIL reset_mid_pre: busy=%b, need 1", busy);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    tot_cnt++;
    if ({busy, done, result, ovf, alu_own, alu_a, alu_b, alu_op} !== 55'd0)
      $display("FAIL reset_mid_outputs: busy=%b done=%b result=%h ovf=%b own=%b alu_a=%h alu_b=%h op=%h, need all 0",
               busy, done, result, ovf, alu_own, alu_a, alu_b, alu_op);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    do_mul(16'd3, 16'd5, 40, 1'b0, 0);
    tot_cnt++;
    if (done_cyc !== 5 || result !== 16'h000F || ovf !== 1'b0)
      $display("FAIL reset_mid_restart: done@%0d result=%h ovf=%b, need @5 000F 0", done_cyc, result, ovf);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; a = 16'h0; b = 16'h0;
    test_reset();
    test_basic();
    test_zero();
    test_start_while_busy();
    test_carry();
    test_flush();
    test_lost_bit();
    test_max();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
